// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: states, opcodes,
// ctrlsig bit positions and field encodings.
package ctrl_pkg;

    localparam int unsigned CTRL_W = 29;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_F_AR  = 4'd1,
        S_F_RD  = 4'd2,
        S_F_IR  = 4'd3,
        S_DEC   = 4'd4,
        S_EX1   = 4'd5,
        S_SKIP  = 4'd6,
        S_OP_AR = 4'd7,
        S_OP_RD = 4'd8,
        S_OP_PC = 4'd9,
        S_M_AR  = 4'd10,
        S_M_RD  = 4'd11,
        S_M_AC  = 4'd12,
        S_M_WR  = 4'd13,
        S_HALT  = 4'd14
    } state_t;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MVAC = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_JMP  = 8'h04;
    localparam logic [7:0] OP_JMPZ = 8'h05;
    localparam logic [7:0] OP_LDM  = 8'h06;
    localparam logic [7:0] OP_STM  = 8'h07;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam int unsigned CS_WTA_EN = 1;
    localparam int unsigned CS_AC_BUS = 2;
    localparam int unsigned CS_AC_ALU = 3;
    localparam int unsigned CS_ALU_LO = 4;
    localparam int unsigned CS_SEL_LO = 7;
    localparam int unsigned CS_BUS_LO = 11;
    localparam int unsigned CS_PC_LD  = 14;
    localparam int unsigned CS_PC_INC = 15;
    localparam int unsigned CS_IR_LD  = 16;
    localparam int unsigned CS_AR_LD  = 17;
    localparam int unsigned CS_DR_LD  = 18;
    localparam int unsigned CS_TR_LD  = 19;
    localparam int unsigned CS_MEM_RD = 20;
    localparam int unsigned CS_MEM_WR = 21;

    localparam logic [2:0] BUS_WTA = 3'd0;
    localparam logic [2:0] BUS_PC  = 3'd1;
    localparam logic [2:0] BUS_IR  = 3'd2;
    localparam logic [2:0] BUS_AR  = 3'd3;
    localparam logic [2:0] BUS_DR  = 3'd4;
    localparam logic [2:0] BUS_AC  = 3'd5;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_F_RD) || (s == S_OP_RD) || (s == S_M_RD) || (s == S_M_WR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from sequencer state and instruction fields to the
// datapath control bundle. Unlisted bits stay 0.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t             state,
    input  logic [7:0]         ir_opcode,
    input  logic [3:0]         ir_reg,
    input  logic               mem_ready,
    output logic [CTRL_W-1:0]  ctrlsig
);

    // Per-state control decode
    always_comb begin
        ctrlsig = '0;
        case (state)
            S_F_AR, S_OP_AR: begin
                ctrlsig[CS_BUS_LO +: 3] = BUS_PC;
                ctrlsig[CS_AR_LD]       = 1'b1;
            end
            S_F_RD, S_OP_RD: begin
                ctrlsig[CS_MEM_RD] = 1'b1;
                if (mem_ready) begin
                    ctrlsig[CS_DR_LD]  = 1'b1;
                    ctrlsig[CS_PC_INC] = 1'b1;
                end else begin
                    ctrlsig[CS_DR_LD]  = 1'b0;
                    ctrlsig[CS_PC_INC] = 1'b0;
                end
            end
            S_F_IR: begin
                ctrlsig[CS_BUS_LO +: 3] = BUS_DR;
                ctrlsig[CS_IR_LD]       = 1'b1;
            end
            S_EX1: begin
                ctrlsig[CS_WTA_EN]      = 1'b1;
                ctrlsig[CS_SEL_LO +: 4] = ir_reg;
                ctrlsig[CS_BUS_LO +: 3] = BUS_WTA;
                case (ir_opcode)
                    OP_MVAC: ctrlsig[CS_AC_BUS] = 1'b1;
                    OP_ADD: begin
                        ctrlsig[CS_ALU_LO +: 3] = ALU_ADD;
                        ctrlsig[CS_AC_ALU]      = 1'b1;
                    end
                    OP_SUB: begin
                        ctrlsig[CS_ALU_LO +: 3] = ALU_SUB;
                        ctrlsig[CS_AC_ALU]      = 1'b1;
                    end
                    default: ctrlsig[CS_ALU_LO +: 3] = ALU_PASS;
                endcase
            end
            S_SKIP: ctrlsig[CS_PC_INC] = 1'b1;
            S_OP_PC: begin
                ctrlsig[CS_BUS_LO +: 3] = BUS_DR;
                ctrlsig[CS_PC_LD]       = 1'b1;
            end
            S_M_AR: begin
                ctrlsig[CS_WTA_EN]      = 1'b1;
                ctrlsig[CS_SEL_LO +: 4] = ir_reg;
                ctrlsig[CS_BUS_LO +: 3] = BUS_WTA;
                ctrlsig[CS_AR_LD]       = 1'b1;
            end
            S_M_RD: begin
                ctrlsig[CS_MEM_RD] = 1'b1;
                if (mem_ready) begin
                    ctrlsig[CS_DR_LD] = 1'b1;
                end else begin
                    ctrlsig[CS_DR_LD] = 1'b0;
                end
            end
            S_M_AC: begin
                ctrlsig[CS_BUS_LO +: 3] = BUS_DR;
                ctrlsig[CS_AC_BUS]      = 1'b1;
            end
            S_M_WR: begin
                ctrlsig[CS_BUS_LO +: 3] = BUS_AC;
                ctrlsig[CS_MEM_WR]      = 1'b1;
            end
            default: ctrlsig = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute sequencer with memory-ready stall, timeout
// and sticky error reporting. Control decode lives in ctrl_decode.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         ir_opcode,
    input  logic [3:0]         ir_reg,
    input  logic               z,
    input  logic               mem_ready,
    output logic [CTRL_W-1:0]  ctrlsig,
    output logic               busy,
    output logic               halted,
    output logic [1:0]         err
);

    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    state_t     state_r;
    state_t     state_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_s;
    logic [1:0] err_r;
    logic [1:0] err_s;
    logic       zq_r;
    logic       zq_s;
    logic       timeout_s;

    // zq is captured in DEC; the branch in DEC sees the value being captured
    assign zq_s      = (state_r == S_DEC) ? z : zq_r;
    assign timeout_s = ({1'b0, wait_cnt_r} + 9'd1) >= TIMEOUT_LIM;

    // Next-state, wait counter and error logic
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = 8'd0;
        err_s      = err_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_F_AR;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_F_AR:  state_s = S_F_RD;
            S_F_IR:  state_s = S_DEC;
            S_F_RD, S_OP_RD, S_M_RD, S_M_WR: begin
                if (mem_ready) begin
                    case (state_r)
                        S_F_RD:  state_s = S_F_IR;
                        S_OP_RD: state_s = S_OP_PC;
                        S_M_RD:  state_s = S_M_AC;
                        default: state_s = S_F_AR;
                    endcase
                end else if (timeout_s) begin
                    state_s = S_HALT;
                    err_s   = ERR_TIMEOUT;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            S_DEC: begin
                case (ir_opcode)
                    OP_NOP:                  state_s = S_F_AR;
                    OP_MVAC, OP_ADD, OP_SUB: state_s = S_EX1;
                    OP_JMP:                  state_s = S_OP_AR;
                    OP_JMPZ:                 state_s = zq_s ? S_OP_AR : S_SKIP;
                    OP_LDM, OP_STM:          state_s = S_M_AR;
                    OP_HALT:                 state_s = S_HALT;
                    default: begin
                        state_s = S_HALT;
                        err_s   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_EX1, S_SKIP, S_OP_PC, S_M_AC: state_s = S_F_AR;
            S_OP_AR: state_s = S_OP_RD;
            S_M_AR: begin
                if (ir_opcode == OP_STM) begin
                    state_s = S_M_WR;
                end else begin
                    state_s = S_M_RD;
                end
            end
            S_HALT:  state_s = S_HALT;
            default: state_s = S_IDLE;
        endcase
    end

    // State, counter, error and zero-flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= 8'd0;
            err_r      <= ERR_NONE;
            zq_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= is_mem_state(state_r) ? wait_cnt_s : 8'd0;
            err_r      <= err_s;
            zq_r       <= zq_s;
        end
    end

    ctrl_decode u_decode (
        .state     (state_r),
        .ir_opcode (ir_opcode),
        .ir_reg    (ir_reg),
        .mem_ready (mem_ready),
        .ctrlsig   (ctrlsig)
    );

    assign busy   = (state_r != S_IDLE) && (state_r != S_HALT);
    assign halted = (state_r == S_HALT);
    assign err    = err_r;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer; expected ctrlsig words are
// hand-computed from the control bit map.
module tb_ctrl_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  ir_opcode;
    logic [3:0]  ir_reg;
    logic        z;
    logic        mem_ready;
    logic [28:0] ctrlsig;
    logic        busy;
    logic        halted;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    localparam logic [28:0] E_ZERO    = 29'h0000000;
    localparam logic [28:0] E_AR_PC   = 29'h0020800;
    localparam logic [28:0] E_RD_RDY  = 29'h0148000;
    localparam logic [28:0] E_RD_WAIT = 29'h0100000;
    localparam logic [28:0] E_F_IR    = 29'h0012000;
    localparam logic [28:0] E_ADD_E   = 29'h000071A;
    localparam logic [28:0] E_SUB_1   = 29'h00000AA;
    localparam logic [28:0] E_SKIP    = 29'h0008000;
    localparam logic [28:0] E_OP_PC   = 29'h0006000;
    localparam logic [28:0] E_M_AR_3  = 29'h0020182;
    localparam logic [28:0] E_M_RDRDY = 29'h0140000;
    localparam logic [28:0] E_M_AC    = 29'h0002004;
    localparam logic [28:0] E_M_WR    = 29'h0202800;

    ctrl_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ir_opcode (ir_opcode),
        .ir_reg    (ir_reg),
        .z         (z),
        .mem_ready (mem_ready),
        .ctrlsig   (ctrlsig),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ir_opcode = 8'h00; ir_reg = 4'h0;
        z = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        chk("rst_ctrlsig", {3'd0, ctrlsig}, {3'd0, E_ZERO});
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // ADD r14, zero-wait memory
        mem_ready = 1'b1; ir_opcode = 8'h02; ir_reg = 4'hE; start = 1'b1;
        tick();
        chk("c1_f_ar", {3'd0, ctrlsig}, {3'd0, E_AR_PC});
        chk("c1_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        tick(); chk("c2_f_rd", {3'd0, ctrlsig}, {3'd0, E_RD_RDY});
        tick(); chk("c3_f_ir", {3'd0, ctrlsig}, {3'd0, E_F_IR});
        tick(); chk("c4_dec", {3'd0, ctrlsig}, {3'd0, E_ZERO});
        chk("c4_busy", {31'd0, busy}, 32'd1);
        tick(); chk("add_ex1", {3'd0, ctrlsig}, {3'd0, E_ADD_E});
        tick(); chk("add_back_f_ar", {3'd0, ctrlsig}, {3'd0, E_AR_PC});

        // SUB r1
        ir_opcode = 8'h03; ir_reg = 4'h1;
        tick(); tick(); tick(); tick();
        chk("sub_ex1", {3'd0, ctrlsig}, {3'd0, E_SUB_1});
        tick(); chk("sub_back_f_ar", {3'd0, ctrlsig}, {3'd0, E_AR_PC});

        // JMPZ not taken
        ir_opcode = 8'h05; z = 1'b0;
        tick(); tick(); tick(); tick();
        chk("jmpz0_skip", {3'd0, ctrlsig}, {3'd0, E_SKIP});
        z = 1'b1;
        tick(); chk("jmpz0_f_ar", {3'd0, ctrlsig}, {3'd0, E_AR_PC});

        // JMPZ taken
        tick(); tick(); tick(); tick();
        chk("jmpz1_op_ar", {3'd0, ctrlsig}, {3'd0, E_AR_PC});
        z = 1'b0;
        tick(); chk("jmpz1_op_rd", {3'd0, ctrlsig}, {3'd0, E_RD_RDY});
        tick(); chk("jmpz1_op_pc", {3'd0, ctrlsig}, {3'd0, E_OP_PC});
        tick(); chk("jmpz1_f_ar", {3'd0, ctrlsig}, {3'd0, E_AR_PC});

        // LDM r3 with ready delayed 3 cycles
        ir_opcode = 8'h06; ir_reg = 4'h3;
        tick(); tick(); tick(); tick();
        chk("ldm_m_ar", {3'd0, ctrlsig}, {3'd0, E_M_AR_3});
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ldm_m_rd_wait", {3'd0, ctrlsig}, {3'd0, E_RD_WAIT});
        end
        mem_ready = 1'b1;
        #1 chk("ldm_m_rd_ready", {3'd0, ctrlsig}, {3'd0, E_M_RDRDY});
        tick(); chk("ldm_m_ac", {3'd0, ctrlsig}, {3'd0, E_M_AC});
        tick(); chk("ldm_f_ar", {3'd0, ctrlsig}, {3'd0, E_AR_PC});

        // Illegal opcode
        ir_opcode = 8'h3C;
        tick(); tick(); tick(); tick();
        chk("ill_ctrlsig", {3'd0, ctrlsig}, {3'd0, E_ZERO});
        chk("ill_halted", {31'd0, halted}, 32'd1);
        chk("ill_busy", {31'd0, busy}, 32'd0);
        chk("ill_err", {30'd0, err}, 32'd1);
        start = 1'b1;
        tick(); tick();
        chk("ill_start_ignored", {31'd0, halted}, 32'd1);
        chk("ill_err_sticky", {30'd0, err}, 32'd1);
        start = 1'b0;
        rst_n = 1'b0;
        #1 chk("ill_rst_err", {30'd0, err}, 32'd0);
        chk("ill_rst_halted", {31'd0, halted}, 32'd0);
        tick(); rst_n = 1'b1; tick();

        // Fetch timeout, mem_ready stuck low
        ir_opcode = 8'h00; mem_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_f_rd_wait", {3'd0, ctrlsig}, {3'd0, E_RD_WAIT});
            chk("to_busy", {31'd0, busy}, 32'd1);
        end
        tick();
        chk("to_halted", {31'd0, halted}, 32'd1);
        chk("to_err", {30'd0, err}, 32'd2);
        chk("to_ctrlsig", {3'd0, ctrlsig}, {3'd0, E_ZERO});
        start = 1'b1; mem_ready = 1'b1;
        tick(); tick();
        chk("to_start_ignored", {31'd0, halted}, 32'd1);
        chk("to_err_sticky", {30'd0, err}, 32'd2);
        start = 1'b0; mem_ready = 1'b0;
        rst_n = 1'b0;
        #1 chk("to_rst_err", {30'd0, err}, 32'd0);
        tick(); rst_n = 1'b1; tick();

        // STM r3, reset asserted mid M_WR
        ir_opcode = 8'h07; ir_reg = 4'h3; mem_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("stm_m_ar", {3'd0, ctrlsig}, {3'd0, E_M_AR_3});
        mem_ready = 1'b0;
        tick(); chk("stm_m_wr", {3'd0, ctrlsig}, {3'd0, E_M_WR});
        #2 rst_n = 1'b0;
        #1 chk("stm_rst_ctrlsig", {3'd0, ctrlsig}, {3'd0, E_ZERO});
        chk("stm_rst_busy", {31'd0, busy}, 32'd0);
        chk("stm_rst_err", {30'd0, err}, 32'd0);
        tick(); rst_n = 1'b1; tick();
        chk("stm_idle_busy", {31'd0, busy}, 32'd0);
        chk("stm_idle_ctrlsig", {3'd0, ctrlsig}, {3'd0, E_ZERO});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
